// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and defaults for the bit-serial subtractor
//
// Purpose : FSM state encoding and default operand width.
// Contents: state_t  - IDLE / SHIFT / DONE
//           DEFAULT_WIDTH - default operand and result width

package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_binary_subtractor.sv
// rtl/full_binary_subtractor.sv - single-bit combinational full subtractor
//
// Purpose : D = A - B - B_in for one bit, with the borrow out of that bit.
// Ports   : A     in  minuend bit
//           B     in  subtrahend bit
//           B_in  in  borrow into this bit
//           D     out difference bit
//           B_out out borrow out of this bit

module full_binary_subtractor (
  input  logic A,
  input  logic B,
  input  logic B_in,
  output logic D,
  output logic B_out
);

  logic ab_diff;

  assign ab_diff = A ^ B;
  assign D       = ab_diff ^ B_in;
  // Borrow when B exceeds A outright, or when A == B and a borrow is pending.
  assign B_out   = (~A & B) | (~ab_diff & B_in);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor with start/busy/done handshake
//
// Purpose : Diff = A - B - B_in (mod 2^WIDTH), one bit per clock through a
//           single shared full-subtractor cell; borrow carried in a flop.
// Ports   : clk    in  clock, rising edge
//           rst    in  asynchronous active-low reset
//           start  in  begin an operation (honoured in IDLE or DONE only)
//           A      in  minuend, captured on the accepting edge
//           B      in  subtrahend, captured on the accepting edge
//           B_in   in  initial borrow, captured on the accepting edge
//           busy   out high while bits are being shifted
//           done   out one-cycle pulse when a new result is valid
//           Diff   out result register
//           B_out  out borrow out of the MSB (unsigned A < B + B_in)
//           V      out two's-complement overflow

module serial_subtractor
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             B_out,
  output logic             V
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   d_sh_q, d_sh_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               b_out_q, b_out_d;
  logic               v_q, v_d;

  logic               cell_d;
  logic               cell_bn;

  // The one shared cell always looks at the current LSBs and the held borrow.
  full_binary_subtractor u_cell (
    .A     (a_sh_q[0]),
    .B     (b_sh_q[0]),
    .B_in  (borrow_q),
    .D     (cell_d),
    .B_out (cell_bn)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    d_sh_d   = d_sh_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    b_out_d  = b_out_q;
    v_d      = v_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = SHIFT;
          a_sh_d   = A;
          b_sh_d   = B;
          d_sh_d   = '0;
          borrow_d = B_in;
          cnt_d    = '0;
        end else begin
          state_d  = IDLE;
        end
      end

      SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        d_sh_d   = {cell_d, d_sh_q[WIDTH-1:1]};
        borrow_d = cell_bn;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Publish on the same edge the MSB is computed; borrow_q here is
          // the borrow into the MSB, so its xor with the borrow out is V.
          diff_d  = {cell_d, d_sh_q[WIDTH-1:1]};
          b_out_d = cell_bn;
          v_d     = borrow_q ^ cell_bn;
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      d_sh_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      b_out_q  <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      d_sh_q   <= d_sh_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      b_out_q  <= b_out_d;
      v_q      <= v_d;
    end
  end

  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign Diff  = diff_q;
  assign B_out = b_out_q;
  assign V     = v_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH 8 and 4) and its cell

module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;

  logic       start8, bin8, busy8, done8, bout8, v8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, busy4, done4, bout4, v4;
  logic [3:0] a4, b4, diff4;
  logic       fa, fb, fbin, fd, fbo;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .B_in(bin8),
    .busy(busy8), .done(done8), .Diff(diff8), .B_out(bout8), .V(v8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .B_in(bin4),
    .busy(busy4), .done(done4), .Diff(diff4), .B_out(bout4), .V(v4)
  );

  full_binary_subtractor u_fbs (
    .A(fa), .B(fb), .B_in(fbin), .D(fd), .B_out(fbo)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int sel_w   = 8;

  logic        cur_busy, cur_done, cur_bout, cur_v;
  logic [31:0] cur_diff;
  logic [33:0] last8, last4;

  always_comb begin
    if (sel_w == 4) begin
      cur_busy = busy4; cur_done = done4; cur_bout = bout4; cur_v = v4;
      cur_diff = {28'd0, diff4};
    end else begin
      cur_busy = busy8; cur_done = done8; cur_bout = bout8; cur_v = v8;
      cur_diff = {24'd0, diff8};
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: {V, B_out, Diff} from plain integer arithmetic.
  function automatic logic [33:0] ref_sub(input int w, input longint a, input longint b, input longint bin);
    longint one, half, r, sa, sb, sr;
    logic [33:0] res;
    one  = 1;
    half = one << (w - 1);
    r    = (a - b - bin) & ((one << (w + 1)) - 1);
    res  = '0;
    res[31:0] = 32'(r & ((one << w) - 1));
    res[32]   = ((r >> w) & one) != 0;
    sa = (a >= half) ? a - 2 * half : a;
    sb = (b >= half) ? b - 2 * half : b;
    sr = sa - sb - bin;
    res[33] = (sr >= half) || (sr < -half);
    return res;
  endfunction

  task automatic drive_ops(input int w, input logic [31:0] a, input logic [31:0] b, input logic bin, input logic s);
    if (w == 4) begin
      a4 = a[3:0]; b4 = b[3:0]; bin4 = bin; start4 = s;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; bin8 = bin; start8 = s;
    end
  endtask

  task automatic set_start(input int w, input logic s);
    if (w == 4) start4 = s;
    else        start8 = s;
  endtask

  task automatic check_result(input string tag, input logic [33:0] exp_r);
    check({tag, "_diff"},  64'(cur_diff), 64'(exp_r[31:0]));
    check({tag, "_b_out"}, 64'(cur_bout), 64'(exp_r[32]));
    check({tag, "_v"},     64'(cur_v),    64'(exp_r[33]));
  endtask

  // One isolated operation, with start toggled randomly while busy.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [33:0] exp_r, prev;
    int cyc, busy_n;
    logic stable;
    sel_w = w;
    prev  = (w == 4) ? last4 : last8;
    exp_r = ref_sub(w, longint'(a), longint'(b), longint'(bin));
    @(negedge clk);
    drive_ops(w, a, b, bin, 1'b1);
    @(posedge clk);
    #1;
    drive_ops(w, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    cyc = 0; busy_n = 0; stable = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (cur_done) break;
      if (cur_busy) busy_n++;
      if ({cur_v, cur_bout, cur_diff} != prev) stable = 1'b0;
      if (cyc > w + 4) begin
        check("timeout", 64'(cyc), 64'(w + 1));
        break;
      end
      set_start(w, 1'($urandom_range(0, 1)));
    end
    set_start(w, 1'b0);
    check("latency",     64'(cyc),      64'(w + 1));
    check("busy_cycles", 64'(busy_n),   64'(w));
    check("hold_prev",   64'(stable),   64'(1));
    check("busy_at_done", 64'(cur_busy), 64'(0));
    check_result("op", exp_r);
    @(negedge clk);
    check("done_pulse", 64'(cur_done), 64'(0));
    check("diff_after", 64'(cur_diff), 64'(exp_r[31:0]));
    if (w == 4) last4 = exp_r;
    else        last8 = exp_r;
  endtask

  // Back-to-back operations with start held high throughout.
  task automatic run_b2b(input int w, input int n);
    logic [31:0] mask, oa [$], ob [$];
    logic        obin [$];
    logic [33:0] prev, exp_r;
    int cyc;
    logic stable;
    sel_w = w;
    mask  = (32'd1 << w) - 32'd1;
    for (int i = 0; i < n; i++) begin
      oa.push_back($urandom & mask);
      ob.push_back($urandom & mask);
      obin.push_back(1'($urandom_range(0, 1)));
    end
    prev = (w == 4) ? last4 : last8;
    @(negedge clk);
    drive_ops(w, oa[0], ob[0], obin[0], 1'b1);
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      exp_r  = ref_sub(w, longint'(oa[i]), longint'(ob[i]), longint'(obin[i]));
      cyc    = 0;
      stable = 1'b1;
      forever begin
        @(negedge clk);
        cyc++;
        if (cur_done) break;
        if ({cur_v, cur_bout, cur_diff} != prev) stable = 1'b0;
        if (cyc == 2) drive_ops(w, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
        if (cyc > w + 4) begin
          check("b2b_timeout", 64'(cyc), 64'(w + 1));
          break;
        end
      end
      check("b2b_spacing", 64'(cyc),    64'(w + 1));
      check("b2b_hold",    64'(stable), 64'(1));
      check_result("b2b", exp_r);
      prev = exp_r;
      if (i < n - 1) drive_ops(w, oa[i + 1], ob[i + 1], obin[i + 1], 1'b1);
      else           set_start(w, 1'b0);
    end
    @(negedge clk);
    check("b2b_end_done", 64'(cur_done), 64'(0));
    if (w == 4) last4 = prev;
    else        last8 = prev;
  endtask

  initial begin
    rst = 1'b0;
    drive_ops(8, 0, 0, 1'b0, 1'b0);
    drive_ops(4, 0, 0, 1'b0, 1'b0);
    fa = 1'b0; fb = 1'b0; fbin = 1'b0;
    last8 = '0;
    last4 = '0;

    repeat (2) @(negedge clk);
    sel_w = 8;
    check("rst_busy", 64'(cur_busy), 64'(0));
    check("rst_done", 64'(cur_done), 64'(0));
    check_result("rst", 34'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      int expect_sub;
      {fa, fb, fbin} = 3'(i);
      #1;
      expect_sub = int'(fa) - int'(fb) - int'(fbin);
      check("cell_d",     64'(fd),  64'(expect_sub & 1));
      check("cell_b_out", 64'(fbo), 64'(expect_sub < 0));
    end

    run_op(8, 32'h05, 32'h03, 1'b0);
    check("plan_05_03", 64'(cur_diff), 64'h02);
    run_op(8, 32'h03, 32'h05, 1'b0);
    check("plan_03_05", 64'({cur_bout, cur_diff[7:0]}), 64'h1FE);
    run_op(8, 32'h00, 32'h00, 1'b1);
    check("plan_00_00_1", 64'({cur_bout, cur_diff[7:0]}), 64'h1FF);
    run_op(8, 32'h80, 32'h01, 1'b0);
    check("plan_80_01", 64'({cur_v, cur_bout, cur_diff[7:0]}), 64'h27F);
    run_op(8, 32'h7F, 32'hFF, 1'b0);
    check("plan_7f_ff", 64'({cur_v, cur_bout, cur_diff[7:0]}), 64'h380);

    run_b2b(8, 5);
    for (int i = 0; i < 20; i++)
      run_op(8, 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    // Asynchronous reset after four shifts of an operation.
    sel_w = 8;
    @(negedge clk);
    drive_ops(8, 32'h5A, 32'h33, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    set_start(8, 1'b0);
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 64'(cur_busy), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", 64'(cur_busy), 64'(0));
    check("arst_done", 64'(cur_done), 64'(0));
    check_result("arst", 34'd0);
    repeat (2) begin
      @(negedge clk);
      check("arst_no_done", 64'(cur_done), 64'(0));
    end
    rst = 1'b1;
    last8 = '0;
    last4 = '0;
    run_op(8, 32'h10, 32'h01, 1'b0);
    check("post_rst_10_01", 64'(cur_diff), 64'h0F);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          run_op(4, 32'(a), 32'(b), 1'(c));
    run_b2b(4, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor computing Diff = A - B - B_in over WIDTH clock cycles.
- One shared single-bit full-subtractor cell is reused every cycle, with the borrow held in a flop between cycles.
- It is the subtract-direction counterpart of the serial add datapath in the Serial-Adder CPU.
- The CPU control unit starts it with a start/busy/done handshake and reads back the parallel result.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2 to 32).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset; 0 forces reset immediately, 1 means run.
- start  input  1  request to begin an operation; sampled only in IDLE or DONE.
- A  input  WIDTH  minuend; sampled on the edge that accepts start.
- B  input  WIDTH  subtrahend; sampled on the edge that accepts start.
- B_in  input  1  initial borrow; sampled on the edge that accepts start.
- busy  output  1  high while the bit-serial shift is in progress.
- done  output  1  one-cycle pulse signalling that a new result is valid.
- Diff  output  WIDTH  result register.
- B_out  output  1  borrow out of the MSB (1 means unsigned A < B + B_in).
- V  output  1  two's-complement overflow flag.

Behaviour:
- Reset (rst = 0), asynchronous and taking effect mid-operation:
  - State goes to IDLE; busy, done, Diff, B_out and V all go to 0.
  - Internal operand shift registers, bit counter and borrow flop are cleared.
  - An interrupted operation produces no done pulse and no partial result.
- States:
  - IDLE: busy = 0, done = 0. If start = 1 at an edge: load A_sh = A, B_sh = B, borrow = B_in, cnt = 0; go to SHIFT.
  - SHIFT: busy = 1, done = 0. On each edge:
    - d = A_sh[0] ^ B_sh[0] ^ borrow
    - bn = (~A_sh[0] & B_sh[0]) | (~(A_sh[0] ^ B_sh[0]) & borrow)
    - D_sh shifts right with d entering at the MSB; A_sh and B_sh shift right; borrow <= bn; cnt <= cnt + 1.
    - When cnt == WIDTH-1, the same edge also updates the outputs: Diff <= final D_sh including d; B_out <= bn; V <= borrow ^ bn (borrow into the MSB xor borrow out of it). State goes to DONE.
  - DONE: busy = 0, done = 1 for exactly one cycle. If start = 1, accept it exactly as IDLE does and go to SHIFT (back-to-back operation). Otherwise go to IDLE.
- Latency: start is accepted at edge k. busy is high over edges k+1 through k+WIDTH. Diff, B_out and V update and done rises at edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- start while busy is ignored; it is not queued.
- A, B and B_in may change freely after the accepting edge.
- Diff, B_out and V hold their last completed value through IDLE and through the whole of any following operation. They change only at a completing edge or on reset.
- Arithmetic is modulo 2^WIDTH. cnt is $clog2(WIDTH) bits and needs no wrap logic, because it is reloaded to 0 on every accept.

Decomposition:
- Package serial_pkg:
  - State typedef enum logic [1:0] {IDLE, SHIFT, DONE}.
  - Localparam DEFAULT_WIDTH = 8.
- Sub-module full_binary_subtractor: purely combinational, ports A, B, B_in -> D, B_out, implementing the d and bn equations above.
  - It is instantiated once in the datapath.
  - It must be verified exhaustively on its own (8 input combinations).
- The top level contains only the FSM, the shift registers, the counter and the output registers.

Test Plan:
- WIDTH = 8. A = 0x05, B = 0x03, B_in = 0, one-cycle start at edge k -> busy high edges k+1..k+8; done pulses once at edge k+8; Diff = 0x02, B_out = 0, V = 0.
- A = 0x03, B = 0x05, B_in = 0 -> Diff = 0xFE, B_out = 1, V = 0. Then A = 0x00, B = 0x00, B_in = 1 -> Diff = 0xFF, B_out = 1, V = 0.
- A = 0x80, B = 0x01 -> Diff = 0x7F, B_out = 0, V = 1. Also A = 0x7F, B = 0xFF -> Diff = 0x80, B_out = 1, V = 1.
- Hold start high continuously with changing operands -> operations complete every 9 cycles. Toggles of start during busy are ignored. The previous Diff stays stable until each new done.
- Assert rst = 0 asynchronously mid-SHIFT after 4 shifts -> busy, done, Diff, B_out and V go to 0 immediately with no done pulse. After release, A = 0x10, B = 0x01 -> Diff = 0x0F.
- WIDTH = 4, exhaustive over all A, B and B_in -> {B_out, Diff} matches (A - B - B_in) mod 32 in 5-bit form; V matches the signed-overflow reference model; done spacing is exactly 5 cycles.
